// File: rtl/dmp_stream_tx.sv
// dmp_stream_tx
//   Transmit side of the DMP partial-pagerank stream. Buffers one partial
//   contribution vector per HW thread (slots may be filled in any order).
//   Once every slot is full and the consumer is ready, the slots are replayed
//   serially, one slot per cycle in ascending order, toward the final/damping
//   stage.
//
//   Optional build macro: DMP_TX_CHECKSUM_EN adds o_stream_checksum.
//
// Ports
//   clock               in   rising-edge clock
//   reset_n             in   asynchronous active-low reset
//   i_wr_valid          in   write of one thread's partial vector
//   i_wr_thread_id      in   slot index of the write
//   i_wr_data           in   64 x NODES_IN_GRAPH partial vector
//   o_wr_ready          out  high only while collecting
//   o_wr_error          out  1-cycle pulse after a rejected write
//   i_stream_ready      in   consumer can accept a whole stream
//   o_stream_valid      out  beat valid
//   o_stream_data       out  beat payload (slot o_stream_beat), 0 outside a stream
//   o_stream_beat       out  slot index of the current beat
//   o_stream_start      out  high with beat 0 only
//   o_stream_done       out  high with the last beat only
//   o_iterations_sent   out  completed streams, wraps modulo 2^32
//   o_stream_checksum   out  (DMP_TX_CHECKSUM_EN only) mod-2^64 sum of all
//                            elements of the current/last stream
//
// State table
//   S_COLLECT | accepting writes until every slot is full
//   S_ARMED   | all slots full, waiting for i_stream_ready
//   S_STREAM  | replaying slots 0..N-1, one beat per cycle

module dmp_stream_tx #(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32,
    localparam int ID_W  = $clog2(NUM_HW_THREADS),
    localparam int VEC_W = 64 * NODES_IN_GRAPH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr_valid,
    input  logic [ID_W-1:0]  i_wr_thread_id,
    input  logic [VEC_W-1:0] i_wr_data,
    output logic             o_wr_ready,
    output logic             o_wr_error,
    input  logic             i_stream_ready,
    output logic             o_stream_valid,
    output logic [VEC_W-1:0] o_stream_data,
    output logic [ID_W-1:0]  o_stream_beat,
    output logic             o_stream_start,
    output logic             o_stream_done,
    output logic [31:0]      o_iterations_sent
`ifdef DMP_TX_CHECKSUM_EN
    ,
    output logic [63:0]      o_stream_checksum
`endif
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ARMED   = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_HW_THREADS-1:0] r_slot_full;
    logic [ID_W-1:0]           r_beat;
    logic [31:0]               r_iterations;
    logic                      r_wr_error;
    logic [VEC_W-1:0]          r_buf [NUM_HW_THREADS];

    logic                      w_id_ok;
    logic                      w_accept;
    logic                      w_last_beat;

    // Widened before comparing so the check stays meaningful when
    // NUM_HW_THREADS is not a power of two.
    assign w_id_ok     = (32'(i_wr_thread_id) < NUM_HW_THREADS);
    assign w_accept    = i_wr_valid && (r_state == S_COLLECT) && w_id_ok
                         && !r_slot_full[i_wr_thread_id];
    assign w_last_beat = (r_state == S_STREAM)
                         && (r_beat == ID_W'(NUM_HW_THREADS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_COLLECT;
            r_slot_full  <= '0;
            r_beat       <= '0;
            r_iterations <= '0;
            r_wr_error   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_error <= i_wr_valid && !w_accept;

            if (w_accept)
                r_slot_full[i_wr_thread_id] <= 1'b1;

            if (r_state == S_STREAM) begin
                if (w_last_beat) begin
                    r_beat       <= '0;
                    r_slot_full  <= '0;
                    r_iterations <= r_iterations + 32'd1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset: it is only observable after a slot
    // has been written, and the output mux forces zeros outside a stream.
    always_ff @(posedge clock) begin
        if (w_accept)
            r_buf[i_wr_thread_id] <= i_wr_data;
    end

    // The full-bitmap test uses the registered bitmap, so the completing
    // write lands first and the transition follows one cycle later.
    always_comb begin
        w_state_next   = r_state;
        o_wr_ready     = 1'b0;
        o_stream_valid = 1'b0;
        o_stream_start = 1'b0;
        o_stream_done  = 1'b0;
        case (r_state)
            S_COLLECT: begin
                o_wr_ready = 1'b1;
                if (&r_slot_full)
                    w_state_next = i_stream_ready ? S_STREAM : S_ARMED;
            end
            S_ARMED: begin
                if (i_stream_ready)
                    w_state_next = S_STREAM;
            end
            S_STREAM: begin
                o_stream_valid = 1'b1;
                o_stream_start = (r_beat == '0);
                o_stream_done  = w_last_beat;
                if (w_last_beat)
                    w_state_next = S_COLLECT;
            end
            default: begin
                w_state_next = S_COLLECT;
            end
        endcase
    end

    assign o_stream_data     = (r_state == S_STREAM) ? r_buf[r_beat] : '0;
    assign o_stream_beat     = (r_state == S_STREAM) ? r_beat : '0;
    assign o_wr_error        = r_wr_error;
    assign o_iterations_sent = r_iterations;

`ifdef DMP_TX_CHECKSUM_EN
    logic [63:0] r_checksum;
    logic [63:0] w_beat_sum;

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < NODES_IN_GRAPH; i++)
            w_beat_sum = w_beat_sum + o_stream_data[i*64 +: 64];
    end

    // Beat 0 restarts the sum; the final total is visible the cycle after
    // the last beat and holds until the next stream starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_checksum <= '0;
        else if (o_stream_valid)
            r_checksum <= (o_stream_start ? 64'd0 : r_checksum) + w_beat_sum;
    end

    assign o_stream_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_dmp_stream_tx.sv
module tb_dmp_stream_tx;

    localparam int NT   = 8;
    localparam int NG   = 32;
    localparam int ID_W = 3;
    localparam int VW   = 64 * NG;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic [ID_W-1:0] wr_thread_id = '0;
    logic [VW-1:0]   wr_data = '0;
    logic            wr_ready;
    logic            wr_error;
    logic            stream_ready = 1'b0;
    logic            stream_valid;
    logic [VW-1:0]   stream_data;
    logic [ID_W-1:0] stream_beat;
    logic            stream_start;
    logic            stream_done;
    logic [31:0]     iterations_sent;
`ifdef DMP_TX_CHECKSUM_EN
    logic [63:0]     stream_checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dmp_stream_tx #(.NUM_HW_THREADS(NT), .NODES_IN_GRAPH(NG)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .i_wr_valid        (wr_valid),
        .i_wr_thread_id    (wr_thread_id),
        .i_wr_data         (wr_data),
        .o_wr_ready        (wr_ready),
        .o_wr_error        (wr_error),
        .i_stream_ready    (stream_ready),
        .o_stream_valid    (stream_valid),
        .o_stream_data     (stream_data),
        .o_stream_beat     (stream_beat),
        .o_stream_start    (stream_start),
        .o_stream_done     (stream_done),
        .o_iterations_sent (iterations_sent)
`ifdef DMP_TX_CHECKSUM_EN
        ,
        .o_stream_checksum (stream_checksum)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic            valid;
        logic [ID_W-1:0] id;
        int              tag;
        logic            exp_err;
        logic            exp_ready;
    } vec_t;

    vec_t vt[10];

    // Element i of a vector tagged t holds t*100 + i.
    function automatic logic [VW-1:0] mk(input int tag);
        logic [VW-1:0] d;
        d = '0;
        for (int i = 0; i < NG; i++)
            d[i*64 +: 64] = 64'(tag * 100 + i);
        return d;
    endfunction

    function automatic logic [63:0] exp_sum(input int base);
        logic [63:0] s;
        s = 0;
        for (int k = 0; k < NT; k++)
            for (int i = 0; i < NG; i++)
                s = s + 64'((base + k) * 100 + i);
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < NG; i++) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("FAIL %s: element %0d got %0h expected %0h",
                             name, i, act[i*64 +: 64], exp[i*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    // Writes slots NT-1 down to low, one per cycle, each expected to be accepted.
    task automatic fill(input int base, input int low);
        for (int k = NT - 1; k >= low; k--) begin
            wr_valid     = 1'b1;
            wr_thread_id = ID_W'(k);
            wr_data      = mk(base + k);
            tick();
            chk("fill_err", 64'(wr_error), 64'd0);
        end
        wr_valid = 1'b0;
    endtask

    // Entered in the beat-0 cycle; returns in the cycle after the last beat.
    task automatic run_beats(input int base, input logic [31:0] exp_iter);
        for (int k = 0; k < NT; k++) begin
            chk("beat_valid", 64'(stream_valid), 64'd1);
            chk("beat_idx",   64'(stream_beat), 64'(k));
            chk("beat_start", 64'(stream_start), 64'(k == 0));
            chk("beat_done",  64'(stream_done), 64'(k == NT - 1));
            chk_vec("beat_data", stream_data, mk(base + k));
            tick();
        end
        chk("post_valid", 64'(stream_valid), 64'd0);
        chk("post_ready", 64'(wr_ready), 64'd1);
        chk("post_iter",  64'(iterations_sent), 64'(exp_iter));
`ifdef DMP_TX_CHECKSUM_EN
        chk("checksum", stream_checksum, exp_sum(base));
`endif
    endtask

    initial begin
        // Slot 3 twice (second rejected), then the rest descending, consumer not ready.
        vt[0] = '{1'b1, 3'd3, 3,  1'b0, 1'b1};
        vt[1] = '{1'b1, 3'd3, 99, 1'b1, 1'b1};
        vt[2] = '{1'b0, 3'd5, 55, 1'b0, 1'b1};
        vt[3] = '{1'b1, 3'd7, 7,  1'b0, 1'b1};
        vt[4] = '{1'b1, 3'd6, 6,  1'b0, 1'b1};
        vt[5] = '{1'b1, 3'd5, 5,  1'b0, 1'b1};
        vt[6] = '{1'b1, 3'd4, 4,  1'b0, 1'b1};
        vt[7] = '{1'b1, 3'd2, 2,  1'b0, 1'b1};
        vt[8] = '{1'b1, 3'd1, 1,  1'b0, 1'b1};
        vt[9] = '{1'b1, 3'd0, 0,  1'b0, 1'b1};

        // Reset state.
        #2;
        chk("rst_ready",  64'(wr_ready), 64'd1);
        chk("rst_error",  64'(wr_error), 64'd0);
        chk("rst_valid",  64'(stream_valid), 64'd0);
        chk("rst_start",  64'(stream_start), 64'd0);
        chk("rst_done",   64'(stream_done), 64'd0);
        chk("rst_iter",   64'(iterations_sent), 64'd0);
        chk_vec("rst_data", stream_data, '0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table-driven collection.
        for (int v = 0; v < 10; v++) begin
            wr_valid     = vt[v].valid;
            wr_thread_id = vt[v].id;
            wr_data      = mk(vt[v].tag);
            tick();
            chk("tbl_err",   64'(wr_error), 64'(vt[v].exp_err));
            chk("tbl_ready", 64'(wr_ready), 64'(vt[v].exp_ready));
            chk("tbl_valid", 64'(stream_valid), 64'd0);
        end
        wr_valid = 1'b0;

        // Armed and held off for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("arm_ready", 64'(wr_ready), 64'd0);
            chk("arm_valid", 64'(stream_valid), 64'd0);
        end
        wr_valid     = 1'b1;
        wr_thread_id = 3'd5;
        wr_data      = mk(77);
        tick();
        wr_valid = 1'b0;
        chk("arm_wr_err", 64'(wr_error), 64'd1);
        chk("arm_valid2", 64'(stream_valid), 64'd0);

        stream_ready = 1'b1;
        tick();
        chk("arm_start", 64'(stream_start), 64'd1);
        run_beats(0, 32'd1);

        // Write in the first COLLECT cycle is accepted; latency to start is t+2.
        fill(10, 0);
        chk("lat_t1_valid", 64'(stream_valid), 64'd0);
        tick();
        chk("lat_t2_start", 64'(stream_start), 64'd1);
        run_beats(10, 32'd2);

        // Reset at beat 4 aborts the stream.
        fill(20, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("pre_rst_beat", 64'(stream_beat), 64'(k));
            tick();
        end
        chk("rst4_beat", 64'(stream_beat), 64'd4);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 64'(stream_valid), 64'd0);
        chk("abort_done",  64'(stream_done), 64'd0);
        chk("abort_iter",  64'(iterations_sent), 64'd0);
        chk("abort_ready", 64'(wr_ready), 64'd1);
        chk_vec("abort_data", stream_data, '0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("abort_quiet", 64'(stream_valid), 64'd0);
        fill(30, 0);
        tick();
        run_beats(30, 32'd1);

        // Counter wrap.
        force dut.r_iterations = 32'hFFFF_FFFF;
        tick();
        release dut.r_iterations;
        chk("wrap_pre", 64'(iterations_sent), 64'hFFFF_FFFF);
        fill(40, 0);
        tick();
        run_beats(40, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
